// File: rtl/str_to_num_pkg.sv
// Shared ASCII constants and parser state encoding for str_to_num.
package str_to_num_pkg;

   localparam logic [7:0] CH_0     = 8'h30;
   localparam logic [7:0] CH_9     = 8'h39;
   localparam logic [7:0] CH_MINUS = 8'h2D;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SIGN,
      ST_DIGITS
   } state_t;

endpackage

// File: rtl/str_to_num_ascii_digit.sv
// Classifies one ASCII byte as digit / minus / other and extracts the digit value.
module ascii_digit
   import str_to_num_pkg::*;
(
   input  logic [7:0] chr,
   output logic       is_dig,
   output logic       is_minus,
   output logic [3:0] d
);

   assign is_dig   = (chr >= CH_0) && (chr <= CH_9);
   assign is_minus = (chr == CH_MINUS);
   assign d        = chr[3:0];

endmodule

// File: rtl/str_to_num.sv
// Parses signed decimal integers from an ASCII byte stream into WIDTH-bit
// two's-complement words on a valid/ready output with a single output register.
module str_to_num
   import str_to_num_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       s_dtm,
   input  logic             s_vld,
   output logic             s_rdy,
   output logic [WIDTH-1:0] m_dtm,
   output logic             m_ovf,
   output logic             m_vld,
   input  logic             m_rdy
);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic             neg, neg_nxt, ovf, ovf_nxt;
   logic             emit, take, is_dig, is_minus;
   logic [3:0]       d;
   logic [WIDTH+3:0] wide;

   ascii_digit u_dig (
      .chr      (s_dtm),
      .is_dig   (is_dig),
      .is_minus (is_minus),
      .d        (d)
   );

   // No skid buffer: input stalls whenever a result is waiting and downstream is not ready.
   assign s_rdy = ~m_vld | m_rdy;
   assign take  = s_vld & s_rdy;
   assign wide  = {4'b0, acc} * (WIDTH+4)'(10) + (WIDTH+4)'(d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         acc   <= '0;
         neg   <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         neg   <= neg_nxt;
         ovf   <= ovf_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      neg_nxt   = neg;
      ovf_nxt   = ovf;
      emit      = 1'b0;
      if (take) begin
         case (state)
            ST_IDLE: begin
               if (is_dig) begin
                  acc_nxt   = WIDTH'(d);
                  neg_nxt   = 1'b0;
                  ovf_nxt   = 1'b0;
                  state_nxt = ST_DIGITS;
               end else if (is_minus) begin
                  neg_nxt   = 1'b1;
                  state_nxt = ST_SIGN;
               end
            end
            ST_SIGN: begin
               if (is_dig) begin
                  acc_nxt   = WIDTH'(d);
                  ovf_nxt   = 1'b0;
                  state_nxt = ST_DIGITS;
               end else if (!is_minus) begin
                  neg_nxt   = 1'b0;
                  state_nxt = ST_IDLE;
               end
            end
            ST_DIGITS: begin
               if (is_dig) begin
                  // Any bit at or above the sign position means |value| > 2^(WIDTH-1)-1.
                  acc_nxt = wide[WIDTH-1:0];
                  ovf_nxt = ovf | (|wide[WIDTH+3:WIDTH-1]);
               end else begin
                  emit      = 1'b1;
                  acc_nxt   = '0;
                  ovf_nxt   = 1'b0;
                  neg_nxt   = is_minus;
                  state_nxt = is_minus ? ST_SIGN : ST_IDLE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // A new emit in the same cycle as a downstream accept reloads without a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_dtm <= '0;
         m_ovf <= 1'b0;
         m_vld <= 1'b0;
      end else if (emit) begin
         m_dtm <= neg ? -acc : acc;
         m_ovf <= ovf;
         m_vld <= 1'b1;
      end else if (m_rdy) begin
         m_vld <= 1'b0;
      end
   end

endmodule

// File: tb/tb_str_to_num.sv
// Directed and randomized bench for str_to_num against a string-level parsing model.
module tb_str_to_num;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_dtm = 8'h00;
   logic        s_vld = 1'b0;
   logic        s_rdy;
   logic [31:0] m_dtm;
   logic        m_ovf;
   logic        m_vld;
   logic        m_rdy = 1'b1;

   int n_assert = 0;
   int n_fail   = 0;
   int stall_cnt = 0;

   logic [32:0] got_q[$];
   logic [32:0] exp_q[$];

   str_to_num #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .s_dtm (s_dtm),
      .s_vld (s_vld),
      .s_rdy (s_rdy),
      .m_dtm (m_dtm),
      .m_ovf (m_ovf),
      .m_vld (m_vld),
      .m_rdy (m_rdy)
   );

   always #5 clk = ~clk;

   // Record every completed output transfer as {ovf, data}.
   always @(negedge clk)
      if (!rst && m_vld && m_rdy) got_q.push_back({m_ovf, m_dtm});

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_num(input bit ovf, input logic [31:0] val);
      exp_q.push_back({ovf, val});
   endtask

   // Reference: scan characters, accumulate magnitude mod 2^32, flag |value| >= 2^31.
   task automatic model(input string s);
      longint mag = 0;
      longint t;
      bit neg = 0, have = 0, ovf = 0;
      byte c;
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         if (c >= 8'h30 && c <= 8'h39) begin
            if (!have) begin
               mag = 0; ovf = 0; have = 1;
            end
            t = mag * 10 + longint'(c - 8'h30);
            if (t >= 64'h8000_0000) ovf = 1;
            mag = t & 64'hFFFF_FFFF;
         end else begin
            if (have) expect_num(ovf, 32'(neg ? -mag : mag));
            have = 0;
            neg  = (c == 8'h2D);
         end
      end
   endtask

   task automatic send(input string s, input bit rnd);
      bit done;
      for (int i = 0; i < s.len(); i++) begin
         s_dtm = s[i];
         done  = 0;
         for (int k = 0; k < 200 && !done; k++) begin
            s_vld = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rnd) m_rdy = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (!s_rdy) stall_cnt++;
            done = s_vld & s_rdy;
            @(posedge clk); #1;
         end
         if (!done) check("send_timeout", 64'(done), 64'd1);
      end
      s_vld = 1'b0;
   endtask

   task automatic drain();
      s_vld = 1'b0;
      m_rdy = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_q(input string tag);
      check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s_%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      string s;
      int    len;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_vld", 64'(m_vld), 64'd0);
      check("rst_m_dtm", 64'(m_dtm), 64'd0);
      check("rst_m_ovf", 64'(m_ovf), 64'd0);
      rst = 1'b0;
      #1;
      check("rst_s_rdy", 64'(s_rdy), 64'd1);
      @(posedge clk); #1;

      // "123\n": m_vld the cycle after the terminator, one pulse only
      send("123\n", 0);
      check("t1_vld", 64'(m_vld), 64'd1);
      check("t1_dtm", 64'(m_dtm), 64'd123);
      check("t1_ovf", 64'(m_ovf), 64'd0);
      @(posedge clk); #1;
      check("t1_pulse", 64'(m_vld), 64'd0);
      expect_num(0, 32'd123);
      drain();
      check_q("t1");

      // negative number, then a sign with no digits
      send("-45 ", 0);
      drain();
      expect_num(0, 32'hFFFF_FFD3);
      check_q("t2a");
      send("- x", 0);
      drain();
      check_q("t2b");

      // back-to-back delimiters, never stalls with m_rdy high
      stall_cnt = 0;
      send("1 2,3;", 0);
      check("t3_no_stall", 64'(stall_cnt), 64'd0);
      drain();
      expect_num(0, 32'd1);
      expect_num(0, 32'd2);
      expect_num(0, 32'd3);
      check_q("t3");

      // downstream stall holds the result and blocks input
      m_rdy = 1'b0;
      send("7 ", 0);
      s_dtm = 8'h38;
      s_vld = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("t4_s_rdy", 64'(s_rdy), 64'd0);
         check("t4_hold", 64'({m_vld, m_dtm}), {31'd0, 1'b1, 32'd7});
         @(posedge clk); #1;
      end
      m_rdy = 1'b1;
      send("8 ", 0);
      drain();
      expect_num(0, 32'd7);
      expect_num(0, 32'd8);
      check_q("t4");

      // overflow boundary
      send("2147483648 2147483647 -2147483648 -2147483647 ", 0);
      drain();
      expect_num(1, 32'h8000_0000);
      expect_num(0, 32'h7FFF_FFFF);
      expect_num(1, 32'h8000_0000);
      expect_num(0, 32'h8000_0001);
      check_q("t5");

      // reset mid-number and mid-output
      send("99", 0);
      rst = 1'b1;
      #1;
      check("t6_rst_vld", 64'(m_vld), 64'd0);
      check("t6_rst_dtm", 64'(m_dtm), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      m_rdy = 1'b0;
      send("6 ", 0);
      check("t6_pend", 64'(m_vld), 64'd1);
      rst = 1'b1;
      #1;
      check("t6_drop", 64'(m_vld), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_rdy = 1'b1;
      send(" 5 ", 0);
      drain();
      expect_num(0, 32'd5);
      check_q("t6");

      // randomized strings with random s_vld gaps and m_rdy backpressure
      for (int it = 0; it < 25; it++) begin
         s = "";
         for (int tok = 0; tok < 6; tok++) begin
            if ($urandom_range(0, 3) == 0) s = {s, "-"};
            len = $urandom_range(0, 12);
            for (int j = 0; j < len; j++) s = $sformatf("%s%c", s, 8'h30 + $urandom_range(0, 9));
            case ($urandom_range(0, 4))
               0: s = {s, " "};
               1: s = {s, ","};
               2: s = {s, "-"};
               3: s = {s, "\n"};
               default: s = {s, "x"};
            endcase
         end
         s = {s, " "};
         model(s);
         send(s, 1);
         drain();
         check_q($sformatf("rnd%0d", it));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
